// File: rtl/fft_pkg.sv
// Shared FFT types and the W16 twiddle table (Q16.16, W = exp(-j*2*pi*k/16)).
package fft_pkg;
  localparam int N_PT   = 16;
  localparam int DATA_W = 16;
  localparam int TW_W   = 32;
  localparam int PAIRS  = N_PT / 2;
  localparam int ADDR_W = $clog2(N_PT);
  localparam int K_W    = $clog2(PAIRS);

  typedef logic signed [DATA_W-1:0] sample_t;
  typedef logic signed [TW_W-1:0]   twiddle_t;
  typedef logic [ADDR_W-1:0]        addr_t;
  typedef logic [K_W-1:0]           k_t;

  // Element 0 is the rightmost entry (k=0).
  localparam logic [PAIRS-1:0][TW_W-1:0] W16_RE = {
    32'hFFFF137D, 32'hFFFF4AFB, 32'hFFFF9E09, 32'h00000000,
    32'h000061F7, 32'h0000B505, 32'h0000EC83, 32'h00010000
  };
  localparam logic [PAIRS-1:0][TW_W-1:0] W16_IM = {
    32'hFFFF9E09, 32'hFFFF4AFB, 32'hFFFF137D, 32'hFFFF0000,
    32'hFFFF137D, 32'hFFFF4AFB, 32'hFFFF9E09, 32'h00000000
  };
endpackage

// File: rtl/fft_stage1_feeder_if.sv
// Sample input and butterfly-pair output bundle for the stage-1 feeder.
interface fft_stage1_feeder_if;
  import fft_pkg::*;

  logic     fir_valid;
  sample_t  fir_d;
  logic     bf_valid;
  logic     bf_ready;
  sample_t  bf_x_real;
  sample_t  bf_x_imag;
  sample_t  bf_y_real;
  sample_t  bf_y_imag;
  twiddle_t bf_wn_real;
  twiddle_t bf_wn_imag;
  k_t       bf_idx;
  logic     bf_last;
  logic     ovf;

  modport master (
    output fir_valid, fir_d, bf_ready,
    input  bf_valid, bf_x_real, bf_x_imag, bf_y_real, bf_y_imag,
           bf_wn_real, bf_wn_imag, bf_idx, bf_last, ovf
  );
  modport slave (
    input  fir_valid, fir_d, bf_ready,
    output bf_valid, bf_x_real, bf_x_imag, bf_y_real, bf_y_imag,
           bf_wn_real, bf_wn_imag, bf_idx, bf_last, ovf
  );
endinterface

// File: rtl/fft_twiddle_rom.sv
// Combinational W16^k lookup from the shared package table.
module fft_twiddle_rom
  import fft_pkg::*;
(
  input  k_t       k,
  output twiddle_t wn_real,
  output twiddle_t wn_imag
);
  assign wn_real = twiddle_t'(W16_RE[k]);
  assign wn_imag = twiddle_t'(W16_IM[k]);
endmodule

// File: rtl/fft_stage1_feeder.sv
// Double-banked collector of 16 real samples issuing the 8 first-stage butterfly pairs.
// FFT_FEED_OUTREG_EN: register all bf_* outputs (one extra cycle latency, full throughput).
module fft_stage1_feeder
  import fft_pkg::*;
(
  input logic clk,
  input logic rst,
  fft_stage1_feeder_if.slave bus
);
  sample_t  bank [2][N_PT];
  logic     wr_bank, rd_bank;
  addr_t    wr_cnt;
  k_t       rd_cnt;
  logic [1:0] bank_full, full_nxt;
  logic     ovf_r;
  logic     wr_en, src_valid, adv;
  sample_t  src_x, src_y;
  twiddle_t tw_re, tw_im, src_wr, src_wi;
  k_t       src_idx;
  logic     src_last;

  assign wr_en     = bus.fir_valid && !bank_full[wr_bank];
  assign src_valid = bank_full[rd_bank];

  fft_twiddle_rom u_rom (.k(rd_cnt), .wn_real(tw_re), .wn_imag(tw_im));

  // Outputs are forced to zero whenever no pair is presented.
  assign src_x    = src_valid ? bank[rd_bank][{1'b0, rd_cnt}] : '0;
  assign src_y    = src_valid ? bank[rd_bank][{1'b1, rd_cnt}] : '0;
  assign src_wr   = src_valid ? tw_re : '0;
  assign src_wi   = src_valid ? tw_im : '0;
  assign src_idx  = src_valid ? rd_cnt : '0;
  assign src_last = src_valid && (rd_cnt == k_t'(PAIRS-1));

  always_ff @(posedge clk) begin
    if (!rst && wr_en) bank[wr_bank][wr_cnt] <= bus.fir_d;
  end

  // Fill and drain always target different banks, so both edits are independent.
  always_comb begin
    full_nxt = bank_full;
    if (wr_en && wr_cnt == addr_t'(N_PT-1)) full_nxt[wr_bank] = 1'b1;
    if (adv && rd_cnt == k_t'(PAIRS-1))     full_nxt[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank   <= 1'b0;
      wr_cnt    <= '0;
      rd_bank   <= 1'b0;
      rd_cnt    <= '0;
      bank_full <= 2'b00;
      ovf_r     <= 1'b0;
    end else begin
      if (bus.fir_valid) begin
        if (bank_full[wr_bank]) begin
          ovf_r <= 1'b1;
        end else if (wr_cnt == addr_t'(N_PT-1)) begin
          wr_cnt  <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_cnt <= wr_cnt + addr_t'(1);
        end
      end
      if (adv) begin
        if (rd_cnt == k_t'(PAIRS-1)) begin
          rd_cnt  <= '0;
          rd_bank <= ~rd_bank;
        end else begin
          rd_cnt <= rd_cnt + k_t'(1);
        end
      end
      bank_full <= full_nxt;
    end
  end

  assign bus.ovf = ovf_r;

`ifdef FFT_FEED_OUTREG_EN
  logic     out_valid, out_last, load;
  sample_t  out_x, out_y;
  twiddle_t out_wr, out_wi;
  k_t       out_idx;

  // A pair leaves the bank when it moves into the stage, not when the consumer takes it.
  assign load = !out_valid || bus.bf_ready;
  assign adv  = src_valid && load;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
      out_wr    <= '0;
      out_wi    <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_valid <= src_valid;
      out_x     <= src_x;
      out_y     <= src_y;
      out_wr    <= src_wr;
      out_wi    <= src_wi;
      out_idx   <= src_idx;
      out_last  <= src_last;
    end
  end

  assign bus.bf_valid   = out_valid;
  assign bus.bf_x_real  = out_x;
  assign bus.bf_y_real  = out_y;
  assign bus.bf_wn_real = out_wr;
  assign bus.bf_wn_imag = out_wi;
  assign bus.bf_idx     = out_idx;
  assign bus.bf_last    = out_last;
`else
  assign adv = src_valid && bus.bf_ready;

  assign bus.bf_valid   = src_valid;
  assign bus.bf_x_real  = src_x;
  assign bus.bf_y_real  = src_y;
  assign bus.bf_wn_real = src_wr;
  assign bus.bf_wn_imag = src_wi;
  assign bus.bf_idx     = src_idx;
  assign bus.bf_last    = src_last;
`endif

  assign bus.bf_x_imag = '0;
  assign bus.bf_y_imag = '0;
endmodule

// File: tb/tb_fft_stage1_feeder.sv
// Directed self-checking bench for fft_stage1_feeder (either output build).
module tb_fft_stage1_feeder;
  import fft_pkg::*;

`ifdef FFT_FEED_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fft_stage1_feeder_if bus();
  fft_stage1_feeder dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [15:0] x, y, xi, yi;
    logic [31:0] wr, wi;
    logic [2:0]  idx;
    logic        last;
    int          cyc;
  } pair_t;

  pair_t q[$];
  int cyc = 0;
  int valid_seen = 0;
  int errors = 0;
  int checks = 0;
  int last_cyc = 0;

  logic [31:0] exp_wr [8] = '{32'h00010000, 32'h0000EC83, 32'h0000B505, 32'h000061F7,
                              32'h00000000, 32'hFFFF9E09, 32'hFFFF4AFB, 32'hFFFF137D};
  logic [31:0] exp_wi [8] = '{32'h00000000, 32'hFFFF9E09, 32'hFFFF4AFB, 32'hFFFF137D,
                              32'hFFFF0000, 32'hFFFF137D, 32'hFFFF4AFB, 32'hFFFF9E09};

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && bus.bf_valid) begin
      pair_t p;
      valid_seen++;
      if (bus.bf_ready) begin
        p.x = bus.bf_x_real;   p.y = bus.bf_y_real;
        p.xi = bus.bf_x_imag;  p.yi = bus.bf_y_imag;
        p.wr = bus.bf_wn_real; p.wi = bus.bf_wn_imag;
        p.idx = bus.bf_idx;    p.last = bus.bf_last;
        p.cyc = cyc;
        q.push_back(p);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic push(input logic [15:0] d);
    bus.fir_valid = 1'b1;
    bus.fir_d     = d;
    last_cyc      = cyc;
    tick();
    bus.fir_valid = 1'b0;
  endtask

  task automatic wait_pairs(input int n, input int budget);
    for (int i = 0; i < budget && q.size() < n; i++) tick();
    repeat (4) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.fir_valid = 1'b0; bus.fir_d = '0; bus.bf_ready = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    @(negedge clk);
    checks += 8;
    if (bus.bf_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.bf_valid); end
    if (bus.bf_idx !== 3'd0) begin errors++; $display("FAIL reset_idx got %0d exp 0", bus.bf_idx); end
    if (bus.bf_last !== 1'b0) begin errors++; $display("FAIL reset_last got %b exp 0", bus.bf_last); end
    if (bus.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", bus.ovf); end
    if (bus.bf_x_real !== 16'h0) begin errors++; $display("FAIL reset_x got %h exp 0", bus.bf_x_real); end
    if (bus.bf_y_real !== 16'h0) begin errors++; $display("FAIL reset_y got %h exp 0", bus.bf_y_real); end
    if (bus.bf_wn_real !== 32'h0) begin errors++; $display("FAIL reset_wr got %h exp 0", bus.bf_wn_real); end
    if (bus.bf_wn_imag !== 32'h0) begin errors++; $display("FAIL reset_wi got %h exp 0", bus.bf_wn_imag); end
    tick();
  endtask

  task automatic test_basic();
    q.delete();
    bus.bf_ready = 1'b1;
    for (int i = 1; i <= 16; i++) push(16'(i));
    wait_pairs(8, 40);
    checks++;
    if (q.size() != 8) begin errors++; $display("FAIL basic_count got %0d exp 8", q.size()); end
    if (q.size() > 0) begin
      checks++;
      if (q[0].cyc != last_cyc + LAT) begin
        errors++; $display("FAIL basic_latency got %0d exp %0d", q[0].cyc - last_cyc, LAT);
      end
    end
    for (int k = 0; k < q.size() && k < 8; k++) begin
      checks += 6;
      if (q[k].x !== 16'(k+1)) begin errors++; $display("FAIL basic_x k=%0d got %h exp %h", k, q[k].x, 16'(k+1)); end
      if (q[k].y !== 16'(k+9)) begin errors++; $display("FAIL basic_y k=%0d got %h exp %h", k, q[k].y, 16'(k+9)); end
      if (q[k].idx !== 3'(k)) begin errors++; $display("FAIL basic_idx k=%0d got %0d", k, q[k].idx); end
      if (q[k].last !== (k == 7)) begin errors++; $display("FAIL basic_last k=%0d got %b", k, q[k].last); end
      if (q[k].wr !== exp_wr[k]) begin errors++; $display("FAIL basic_wr k=%0d got %h exp %h", k, q[k].wr, exp_wr[k]); end
      if (q[k].wi !== exp_wi[k]) begin errors++; $display("FAIL basic_wi k=%0d got %h exp %h", k, q[k].wi, exp_wi[k]); end
      if (k > 0) begin
        checks++;
        if (q[k].cyc != q[k-1].cyc + 1) begin errors++; $display("FAIL basic_bubble k=%0d gap %0d exp 1", k, q[k].cyc - q[k-1].cyc); end
      end
    end
  endtask

  task automatic test_negative();
    q.delete();
    bus.bf_ready = 1'b1;
    for (int i = 1; i <= 16; i++) push(16'(-i));
    wait_pairs(8, 40);
    checks++;
    if (q.size() != 8) begin errors++; $display("FAIL neg_count got %0d exp 8", q.size()); end
    for (int k = 0; k < q.size() && k < 8; k++) begin
      checks += 4;
      if (q[k].x !== 16'(-(k+1))) begin errors++; $display("FAIL neg_x k=%0d got %h exp %h", k, q[k].x, 16'(-(k+1))); end
      if (q[k].y !== 16'(-(k+9))) begin errors++; $display("FAIL neg_y k=%0d got %h exp %h", k, q[k].y, 16'(-(k+9))); end
      if (q[k].xi !== 16'h0) begin errors++; $display("FAIL neg_xi k=%0d got %h exp 0", k, q[k].xi); end
      if (q[k].yi !== 16'h0) begin errors++; $display("FAIL neg_yi k=%0d got %h exp 0", k, q[k].yi); end
    end
    if (q.size() > 2) begin
      checks += 2;
      if (q[2].wr !== 32'h0000B505) begin errors++; $display("FAIL neg_wr2 got %h exp 0000B505", q[2].wr); end
      if (q[2].wi !== 32'hFFFF4AFB) begin errors++; $display("FAIL neg_wi2 got %h exp FFFF4AFB", q[2].wi); end
    end
  endtask

  task automatic test_stall();
    q.delete();
    bus.bf_ready = 1'b0;
    for (int i = 1; i <= 16; i++) push(16'(i));
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.bf_valid) break;
    end
    tick();
    bus.bf_ready = 1'b1;
    repeat (3) tick();
    bus.bf_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks += 4;
      if (bus.bf_valid !== 1'b1) begin errors++; $display("FAIL stall_valid cyc=%0d got %b exp 1", i, bus.bf_valid); end
      if (bus.bf_idx !== 3'd3) begin errors++; $display("FAIL stall_idx cyc=%0d got %0d exp 3", i, bus.bf_idx); end
      if (bus.bf_x_real !== 16'd4) begin errors++; $display("FAIL stall_x cyc=%0d got %h exp 0004", i, bus.bf_x_real); end
      if (bus.bf_y_real !== 16'd12) begin errors++; $display("FAIL stall_y cyc=%0d got %h exp 000c", i, bus.bf_y_real); end
      tick();
    end
    bus.bf_ready = 1'b1;
    wait_pairs(8, 40);
    checks++;
    if (q.size() != 8) begin errors++; $display("FAIL stall_count got %0d exp 8", q.size()); end
    for (int k = 0; k < q.size() && k < 8; k++) begin
      checks += 2;
      if (q[k].idx !== 3'(k)) begin errors++; $display("FAIL stall_seq k=%0d got %0d", k, q[k].idx); end
      if (q[k].x !== 16'(k+1)) begin errors++; $display("FAIL stall_data k=%0d got %h exp %h", k, q[k].x, 16'(k+1)); end
    end
  endtask

  task automatic test_back_to_back();
    q.delete();
    bus.bf_ready = 1'b1;
    for (int i = 0; i < 48; i++) push(16'(100 + i));
    wait_pairs(24, 60);
    checks += 2;
    if (q.size() != 24) begin errors++; $display("FAIL b2b_count got %0d exp 24", q.size()); end
    if (bus.ovf !== 1'b0) begin errors++; $display("FAIL b2b_ovf got %b exp 0", bus.ovf); end
    for (int n = 0; n < q.size() && n < 24; n++) begin
      checks += 3;
      if (q[n].x !== 16'(100 + 16*(n/8) + n%8)) begin errors++; $display("FAIL b2b_x n=%0d got %h", n, q[n].x); end
      if (q[n].y !== 16'(108 + 16*(n/8) + n%8)) begin errors++; $display("FAIL b2b_y n=%0d got %h", n, q[n].y); end
      if (q[n].idx !== 3'(n%8)) begin errors++; $display("FAIL b2b_idx n=%0d got %0d", n, q[n].idx); end
    end
  endtask

  task automatic test_overflow();
    q.delete();
    bus.bf_ready = 1'b0;
    for (int i = 0; i < 32; i++) push(16'(200 + i));
    tick();
    checks++;
    if (bus.ovf !== 1'b0) begin errors++; $display("FAIL ovf_early got %b exp 0", bus.ovf); end
    push(16'(232));
    tick();
    checks++;
    if (bus.ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", bus.ovf); end
    bus.bf_ready = 1'b1;
    wait_pairs(16, 50);
    checks += 2;
    if (q.size() != 16) begin errors++; $display("FAIL ovf_count got %0d exp 16", q.size()); end
    if (bus.ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", bus.ovf); end
    for (int n = 0; n < q.size() && n < 16; n++) begin
      checks += 2;
      if (q[n].x !== 16'(200 + 16*(n/8) + n%8)) begin errors++; $display("FAIL ovf_x n=%0d got %h", n, q[n].x); end
      if (q[n].y !== 16'(208 + 16*(n/8) + n%8)) begin errors++; $display("FAIL ovf_y n=%0d got %h", n, q[n].y); end
    end
    if (q.size() > 8) begin
      checks++;
      if (q[8].cyc != q[7].cyc + 1) begin errors++; $display("FAIL ovf_bubble gap %0d exp 1", q[8].cyc - q[7].cyc); end
    end
  endtask

  task automatic test_rst_mid();
    do_reset();
    tick();
    checks++;
    if (bus.ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b exp 0", bus.ovf); end
    q.delete();
    bus.bf_ready = 1'b1;
    for (int i = 0; i < 10; i++) push(16'(500 + i));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    valid_seen = 0;
    repeat (20) tick();
    checks++;
    if (valid_seen != 0 || q.size() != 0) begin
      errors++; $display("FAIL rst_partial valid_cycles=%0d pairs=%0d exp 0", valid_seen, q.size());
    end
    q.delete();
    for (int i = 0; i < 16; i++) push(16'(300 + i));
    wait_pairs(8, 40);
    checks++;
    if (q.size() != 8) begin errors++; $display("FAIL rst_count got %0d exp 8", q.size()); end
    for (int k = 0; k < q.size() && k < 8; k++) begin
      checks += 2;
      if (q[k].x !== 16'(300 + k)) begin errors++; $display("FAIL rst_x k=%0d got %h exp %h", k, q[k].x, 16'(300 + k)); end
      if (q[k].y !== 16'(308 + k)) begin errors++; $display("FAIL rst_y k=%0d got %h exp %h", k, q[k].y, 16'(308 + k)); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_stall();
    test_back_to_back();
    test_overflow();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end
endmodule
